// File: rtl/cpu_clock_gen_if.sv
// cpu_clock_gen_if: control and time-base bus of the CPU/DRAM clock generator.
// Revision: 1.0
`default_nettype none

interface cpu_clock_gen_if #(
  parameter int NUM_CH = 1,
  parameter int RATIO  = 2,
  parameter int CNT_W  = 64
);
  localparam int PH_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic              enable;
  logic              clear;
  logic [NUM_CH-1:0] ch_en;
  logic              limit_en;
  logic [CNT_W-1:0]  limit;
  logic [CNT_W-1:0]  cpu_cycle;
  logic [CNT_W-1:0]  dram_cycle;
  logic [PH_W-1:0]   dram_phase;
  logic [NUM_CH-1:0] dram_tick;
  logic              running;
  logic              done;

  modport master (
    output enable, clear, ch_en, limit_en, limit,
    input  cpu_cycle, dram_cycle, dram_phase, dram_tick, running, done
  );

  modport slave (
    input  enable, clear, ch_en, limit_en, limit,
    output cpu_cycle, dram_cycle, dram_phase, dram_tick, running, done
  );
endinterface

`default_nettype wire

// File: rtl/cpu_clock_gen.sv
// cpu_clock_gen: CPU cycle counter with integer-ratio DRAM clock strobes and halt-at-limit.
// Revision: 1.0
`default_nettype none

module cpu_clock_gen #(
  parameter int NUM_CH = 1,
  parameter int RATIO  = 2,
  parameter int CNT_W  = 64
) (
  input  logic            clock,
  input  logic            reset,
  cpu_clock_gen_if.slave  bus
);
  localparam int              PH_W   = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [PH_W-1:0] c_LAST = PH_W'(RATIO - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_running;
  logic              r_done;
  logic [CNT_W-1:0]  r_cpu_cycle;
  logic [CNT_W-1:0]  r_dram_cycle;
  logic [PH_W-1:0]   r_phase;
  logic [NUM_CH-1:0] r_tick;

  logic w_hit;
  logic w_wrap;

  assign w_hit  = bus.limit_en && (r_cpu_cycle == bus.limit);
  assign w_wrap = (r_phase == c_LAST);

  // Counters only advance on RUN->RUN edges, so the count step lives in that branch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_running    <= 1'b0;
      r_done       <= 1'b0;
      r_cpu_cycle  <= '0;
      r_dram_cycle <= '0;
      r_phase      <= '0;
      r_tick       <= '0;
    end else if (bus.clear) begin
      r_state      <= S_IDLE;
      r_running    <= 1'b0;
      r_done       <= 1'b0;
      r_cpu_cycle  <= '0;
      r_dram_cycle <= '0;
      r_phase      <= '0;
      r_tick       <= '0;
    end else begin
      r_tick <= '0;
      case (r_state)
        S_IDLE: begin
          if (!bus.enable) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
          end
        end
        S_RUN: begin
          if (bus.enable) begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
          end else if (w_hit) begin
            r_state   <= S_DONE;
            r_running <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_cpu_cycle <= r_cpu_cycle + CNT_W'(1);
            r_phase     <= w_wrap ? '0 : r_phase + PH_W'(1);
            if (w_wrap) begin
              r_dram_cycle <= r_dram_cycle + CNT_W'(1);
              r_tick       <= bus.ch_en;
            end
          end
        end
        S_DONE: begin
          if (bus.enable) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end else if (!w_hit) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
            r_done    <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_running <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_cycle  = r_cpu_cycle;
  assign bus.dram_cycle = r_dram_cycle;
  assign bus.dram_phase = r_phase;
  assign bus.dram_tick  = r_tick;
  assign bus.running    = r_running;
  assign bus.done       = r_done;
endmodule

`default_nettype wire

// File: tb/tb_cpu_clock_gen.sv
// tb_cpu_clock_gen: directed checks of three cpu_clock_gen configurations.
// Revision: 1.0
`default_nettype none

module tb_cpu_clock_gen;
  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;

  cpu_clock_gen_if #(.NUM_CH(2), .RATIO(4), .CNT_W(64)) ifa ();
  cpu_clock_gen_if #(.NUM_CH(1), .RATIO(3), .CNT_W(64)) ifb ();
  cpu_clock_gen_if #(.NUM_CH(1), .RATIO(1), .CNT_W(4))  ifc ();

  cpu_clock_gen #(.NUM_CH(2), .RATIO(4), .CNT_W(64)) u_dut_a (.clock(clock), .reset(reset), .bus(ifa));
  cpu_clock_gen #(.NUM_CH(1), .RATIO(3), .CNT_W(64)) u_dut_b (.clock(clock), .reset(reset), .bus(ifb));
  cpu_clock_gen #(.NUM_CH(1), .RATIO(1), .CNT_W(4))  u_dut_c (.clock(clock), .reset(reset), .bus(ifc));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    int pulses;
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    ifa.enable = 1'b1; ifa.clear = 1'b0; ifa.ch_en = '0; ifa.limit_en = 1'b0; ifa.limit = '0;
    ifb.enable = 1'b1; ifb.clear = 1'b0; ifb.ch_en = '0; ifb.limit_en = 1'b0; ifb.limit = '0;
    ifc.enable = 1'b1; ifc.clear = 1'b0; ifc.ch_en = '0; ifc.limit_en = 1'b0; ifc.limit = '0;

    step(2);
    check("rst_cpu", ifa.cpu_cycle, 0);
    check("rst_running", ifa.running, 0);
    check("rst_done", ifa.done, 0);
    reset = 1'b0;

    // Run to cpu_cycle=37, then hit it with an asynchronous reset between edges.
    ifa.enable = 1'b0;
    step(38);
    check("run37_cpu", ifa.cpu_cycle, 37);
    check("run37_dram", ifa.dram_cycle, 9);
    check("run37_phase", ifa.dram_phase, 1);
    check("run37_running", ifa.running, 1);
    #2 reset = 1'b1;
    #1;
    check("async_cpu", ifa.cpu_cycle, 0);
    check("async_dram", ifa.dram_cycle, 0);
    check("async_phase", ifa.dram_phase, 0);
    check("async_tick", ifa.dram_tick, 0);
    check("async_running", ifa.running, 0);
    check("async_done", ifa.done, 0);
    #1 reset = 1'b0;
    step(1);
    check("restart_running", ifa.running, 1);
    check("restart_cpu0", ifa.cpu_cycle, 0);
    step(1);
    check("restart_cpu1", ifa.cpu_cycle, 1);

    // Ratio 4 with only channel 1 enabled.
    ifa.ch_en = 2'b10;
    ifa.clear = 1'b1;
    step(1);
    ifa.clear = 1'b0;
    check("clr_cpu", ifa.cpu_cycle, 0);
    check("clr_running", ifa.running, 0);
    step(1);
    check("ticks_start_running", ifa.running, 1);
    pulses = 0;
    for (int c = 1; c <= 20; c++) begin
      step(1);
      check($sformatf("tick_c%0d", c), ifa.dram_tick, (c % 4 == 0) ? 2'b10 : 2'b00);
      if (ifa.dram_tick[1]) pulses++;
    end
    check("ticks_pulses", pulses, 5);
    check("ticks_cpu", ifa.cpu_cycle, 20);
    check("ticks_dram", ifa.dram_cycle, 5);
    check("ticks_phase", ifa.dram_phase, 0);

    // Halt at limit 10, then raise it to 15.
    ifa.limit_en = 1'b1;
    ifa.limit    = 64'd10;
    ifa.clear    = 1'b1;
    step(1);
    ifa.clear = 1'b0;
    step(15);
    check("lim10_cpu", ifa.cpu_cycle, 10);
    check("lim10_done", ifa.done, 1);
    check("lim10_running", ifa.running, 0);
    ifa.limit = 64'd15;
    step(1);
    check("lim15_resume_running", ifa.running, 1);
    check("lim15_resume_done", ifa.done, 0);
    check("lim15_resume_cpu", ifa.cpu_cycle, 10);
    step(1);
    check("lim15_cpu11", ifa.cpu_cycle, 11);
    step(10);
    check("lim15_cpu", ifa.cpu_cycle, 15);
    check("lim15_done", ifa.done, 1);
    check("lim15_dram", ifa.dram_cycle, 3);
    check("lim15_phase", ifa.dram_phase, 3);

    // Clear from DONE.
    ifa.limit_en = 1'b0;
    ifa.clear    = 1'b1;
    step(1);
    ifa.clear = 1'b0;
    check("clrdone_cpu", ifa.cpu_cycle, 0);
    check("clrdone_dram", ifa.dram_cycle, 0);
    check("clrdone_done", ifa.done, 0);
    check("clrdone_running", ifa.running, 0);
    step(1);
    check("clrdone_rerun", ifa.running, 1);
    ifa.enable = 1'b1;

    // Ratio 3: pause at phase 2 and resume without phase slip.
    ifb.ch_en  = 1'b1;
    ifb.enable = 1'b0;
    step(6);
    check("p_cpu", ifb.cpu_cycle, 5);
    check("p_phase", ifb.dram_phase, 2);
    check("p_dram", ifb.dram_cycle, 1);
    ifb.enable = 1'b1;
    step(1);
    check("p_idle_running", ifb.running, 0);
    check("p_idle_tick", ifb.dram_tick, 0);
    step(6);
    check("p_hold_cpu", ifb.cpu_cycle, 5);
    check("p_hold_phase", ifb.dram_phase, 2);
    check("p_hold_dram", ifb.dram_cycle, 1);
    check("p_hold_tick", ifb.dram_tick, 0);
    ifb.enable = 1'b0;
    step(1);
    check("p_res_running", ifb.running, 1);
    check("p_res_cpu", ifb.cpu_cycle, 5);
    check("p_res_dram", ifb.dram_cycle, 1);
    step(1);
    check("p_res_cpu6", ifb.cpu_cycle, 6);
    check("p_res_dram2", ifb.dram_cycle, 2);
    check("p_res_phase0", ifb.dram_phase, 0);
    check("p_res_tick", ifb.dram_tick, 1);
    step(1);
    check("p_res_tick_low", ifb.dram_tick, 0);
    ifb.enable = 1'b1;

    // Ratio 1 with a 4-bit counter that wraps.
    ifc.ch_en  = 1'b1;
    ifc.enable = 1'b0;
    step(1);
    check("r1_first_tick", ifc.dram_tick, 0);
    check("r1_running", ifc.running, 1);
    for (int c = 1; c <= 17; c++) begin
      step(1);
      check($sformatf("r1_tick_c%0d", c), ifc.dram_tick, 1);
    end
    check("r1_cpu", ifc.cpu_cycle, 1);
    check("r1_dram", ifc.dram_cycle, 1);
    check("r1_phase", ifc.dram_phase, 0);
    ifc.enable = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/cpu_clock_gen.md
# cpu_clock_gen

Parametrised CPU/DRAM time base for the memory-controller simulation. Counts CPU cycles of the 3.2 GHz core clock and derives per-channel DRAM clock-edge strobes at a fixed integer CPU:DRAM ratio. It also maintains a DRAM cycle counter and halts on a programmable CPU-cycle limit. The trace parser, scheduler and DRAM command timers all read their notion of time from this block.

## Interface
- NUM_CH, 1: number of DRAM channels; each gets its own tick strobe.
- RATIO, 2: CPU clocks per DRAM clock; legal range 1..16.
- CNT_W, 64: width of both cycle counters.
- PH_W, derived: max(1, $clog2(RATIO)); not overridden.

- clock  in  1  CPU clock.
- reset  in  1  asynchronous, active-high; forces all state to reset values immediately.
- enable  in  1  active-low run request: 0 = run, 1 = pause.
- clear  in  1  synchronous clear of counters, phase and ticks.
- ch_en  in  NUM_CH  per-channel tick gate.
- limit_en  in  1  enables halt-at-limit.
- limit  in  CNT_W  CPU cycle value at which counting halts.
- cpu_cycle  out  CNT_W  CPU cycles counted.
- dram_cycle  out  CNT_W  DRAM cycles counted.
- dram_phase  out  PH_W  position of the current CPU cycle within the DRAM cycle, 0..RATIO-1.
- dram_tick  out  NUM_CH  one-cycle strobe, asserted the cycle after a DRAM cycle completes.
- running  out  1  high while the state is RUN.
- done  out  1  high while the state is DONE.

## Operation
- States:
  - IDLE is the reset state.
  - RUN counts.
  - DONE is entered when the limit is hit.
  - running and done decode the state only; there is no extra latency.
- Transitions are evaluated at each rising edge. Priority: reset, then clear, then the rules below.
  - IDLE -> RUN when enable==0; otherwise stay in IDLE.
  - RUN -> IDLE when enable==1.
  - RUN -> DONE when enable==0, limit_en==1 and cpu_cycle==limit.
  - Otherwise RUN -> RUN.
  - DONE -> IDLE when enable==1.
  - DONE -> RUN when enable==0 and !(limit_en && limit==cpu_cycle).
  - Otherwise DONE -> DONE.
- Advance condition: the counters advance on an edge only if the state is RUN and the next state is RUN. Consequences:
  - No count on the IDLE->RUN edge.
  - No count on a pause edge.
  - No count on the limit-hit edge.
- When the counters advance:
  - cpu_cycle += 1, modulo 2^CNT_W.
  - dram_phase = (dram_phase==RATIO-1) ? 0 : dram_phase+1.
- DRAM cycle completion: when the counters advance with dram_phase==RATIO-1:
  - dram_cycle += 1, modulo 2^CNT_W.
  - dram_tick[i] <= ch_en[i] for the next cycle.
  - On every other edge, dram_tick <= 0.
- RATIO==1: dram_phase stays 0; dram_cycle tracks cpu_cycle; ticks fire on every advance.
- Limit behaviour:
  - cpu_cycle stops at exactly limit.
  - A limit below the current cpu_cycle is only reached after counter wrap.
  - Changing limit or dropping limit_en while in DONE resumes counting on the next edge.
- clear:
  - Zeroes cpu_cycle, dram_cycle, dram_phase and dram_tick.
  - Forces the state to IDLE regardless of enable.
  - Run resumes from IDLE per the rules above.
- Pause: all outputs hold their values in IDLE, except dram_tick, which is 0.

## Timing
- Reset values:
  - cpu_cycle=0, dram_cycle=0, dram_phase=0.
  - dram_tick=0, running=0, done=0.
  - State is IDLE.
- Reset asserted mid-operation clears everything asynchronously. Deassertion is taken at the next edge; run restarts one edge later if enable==0.
- From enable falling to the first cpu_cycle increment: 2 edges (IDLE->RUN, then the first count).
- dram_tick latency: high for exactly one cycle, the cycle after the edge on which dram_cycle increments.
- With continuous run, the tick period is exactly RATIO cycles. With RATIO==1, the tick is held high continuously.
- Pause mid-DRAM-cycle preserves dram_phase. Resume continues the same DRAM cycle, with no phase slip.
- clear and enable==1 on the same edge: the clear takes effect and the state is IDLE.
- ch_en is sampled on the completion edge only. Toggling ch_en between completion edges has no effect on the tick.

## Test plan
- Reset → outputs: assert reset mid-run with cpu_cycle=37 → all outputs 0 immediately (without waiting for an edge). Deassert reset, hold enable=0 → running=1 after 1 edge; cpu_cycle=1 after 2 edges.
- Ratio and ticks: RATIO=4, NUM_CH=2, ch_en=2'b10, run 20 counting edges → cpu_cycle=20, dram_cycle=5, dram_phase=0, five single-cycle pulses on dram_tick[1] spaced 4 cycles apart, dram_tick[0] never high.
- Pause and resume: RATIO=3, pause at dram_phase=2 for 7 cycles → counters frozen, dram_tick=0. Resume → dram_cycle increments on the first counting edge after resume.
- Limit hit: limit_en=1, limit=10 → cpu_cycle stops at 10, done=1, running=0. Set limit=15 → resumes next edge, halts at 15.
- RATIO=1 and wrap: CNT_W=4, run 17 counting edges → cpu_cycle=1, dram_cycle=1, tick asserted every counting cycle.
- clear in DONE: from the DONE state, pulse clear for one edge → counters 0, state IDLE, done=0. Hold enable=0 with limit_en=0 → running=1 after 1 edge.
